// File: rtl/alu_ctrl_seq.sv
// Registered ALU-control stage between ID and EX: decodes funct/ALUOp, handles
// valid/ready with stall and flush, and sequences multi-cycle mult/div.
module alu_ctrl_seq #(
  parameter int unsigned FUNCT_W    = 6,
  parameter int unsigned OP_W       = 3,
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic [OP_W-1:0]    aluop_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [CTRL_W-1:0]  alu_ctrl_o,
  output logic [1:0]         result_sel_o,
  output logic               left_right_o,
  output logic               shift_var_o,
  output logic               muldiv_start_o,
  output logic               muldiv_op_o,
  output logic               muldiv_abort_o,
  output logic               busy_o,
  output logic               illegal_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               accept;

  logic [CTRL_W-1:0]  d_ctrl;
  logic [1:0]         d_sel;
  logic               d_lr;
  logic               d_var;
  logic               d_md;
  logic               d_op;
  logic               d_ill;

  // Gated by rst_i so the requester sees no acceptance while in reset.
  assign ready_o = rst_i && (state == IDLE) && !(valid_o && stall_i);
  assign accept  = valid_i && ready_o && !flush_i;

  // Combinational decode of the incoming request.
  always_comb begin
    d_ctrl = '0;
    d_sel  = 2'd0;
    d_lr   = 1'b0;
    d_var  = 1'b0;
    d_md   = 1'b0;
    d_op   = 1'b0;
    d_ill  = 1'b0;
    if (aluop_i == OP_W'(3'b000)) begin
      case (funct_i)
        FUNCT_W'(6'b100001): d_ctrl = CTRL_W'(4'b0010);
        FUNCT_W'(6'b100011): d_ctrl = CTRL_W'(4'b0110);
        FUNCT_W'(6'b100100): d_ctrl = CTRL_W'(4'b0000);
        FUNCT_W'(6'b100101): d_ctrl = CTRL_W'(4'b0001);
        FUNCT_W'(6'b101010): d_ctrl = CTRL_W'(4'b0111);
        FUNCT_W'(6'b000000): d_sel = 2'd1;
        FUNCT_W'(6'b000100): begin d_sel = 2'd1; d_var = 1'b1; end
        FUNCT_W'(6'b000011): begin d_sel = 2'd1; d_lr = 1'b1; end
        FUNCT_W'(6'b000111): begin d_sel = 2'd1; d_lr = 1'b1; d_var = 1'b1; end
        FUNCT_W'(6'b011000): begin d_sel = 2'd2; d_md = 1'b1; end
        FUNCT_W'(6'b011010): begin d_sel = 2'd2; d_md = 1'b1; d_op = 1'b1; end
        default:             d_ill = 1'b1;
      endcase
    end else begin
      case (aluop_i)
        OP_W'(3'b001): d_ctrl = CTRL_W'(4'b0010);
        OP_W'(3'b010): d_ctrl = CTRL_W'(4'b0111);
        OP_W'(3'b011): d_ctrl = CTRL_W'(4'b0110);
        OP_W'(3'b100): d_ctrl = CTRL_W'(4'b0110);
        OP_W'(3'b110): d_ctrl = CTRL_W'(4'b0001);
        OP_W'(3'b101): d_sel  = 2'd1;
        default:       d_ill  = 1'b1;
      endcase
    end
  end

  // State, iteration counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      cnt            <= '0;
      valid_o        <= 1'b0;
      alu_ctrl_o     <= '0;
      result_sel_o   <= 2'd0;
      left_right_o   <= 1'b0;
      shift_var_o    <= 1'b0;
      muldiv_start_o <= 1'b0;
      muldiv_op_o    <= 1'b0;
      muldiv_abort_o <= 1'b0;
      busy_o         <= 1'b0;
      illegal_o      <= 1'b0;
    end else if (flush_i) begin
      muldiv_abort_o <= (state == BUSY);
      muldiv_start_o <= 1'b0;
      state          <= IDLE;
      cnt            <= '0;
      valid_o        <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      muldiv_start_o <= 1'b0;
      muldiv_abort_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            alu_ctrl_o   <= d_ctrl;
            result_sel_o <= d_sel;
            left_right_o <= d_lr;
            shift_var_o  <= d_var;
            muldiv_op_o  <= d_op;
            illegal_o    <= d_ill;
            if (d_md) begin
              state          <= BUSY;
              cnt            <= d_op ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
              muldiv_start_o <= 1'b1;
              busy_o         <= 1'b1;
              valid_o        <= 1'b0;
            end else begin
              valid_o <= 1'b1;
            end
          end else if (!(valid_o && stall_i)) begin
            valid_o <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state   <= IDLE;
            valid_o <= 1'b1;
            busy_o  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Registered, parametrised ALU-control stage for the pipelined CPU; sits between ID and EX.
- Decodes funct/ALUOp into ALU control, result-select and shifter controls, as the single-cycle decoder does. Adds a valid/ready handshake, stall and flush, and illegal-op flagging.
- Sequences multi-cycle mult/div through an iteration counter: asserts busy_o and withholds valid_o until the operation completes.

Parameters:
FUNCT_W, 6, funct field width
OP_W, 3, ALUOp width
CTRL_W, 4, ALU control width
MUL_CYCLES, 4, mult latency in cycles (>=2)
DIV_CYCLES, 32, div latency in cycles (>=2)
CNT_W, 6, counter width (must hold max(MUL_CYCLES,DIV_CYCLES)-1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
valid_i  in  1  decode request present
funct_i  in  FUNCT_W  R-type funct field
aluop_i  in  OP_W  ALUOp from main control
stall_i  in  1  downstream hold
flush_i  in  1  synchronous squash
ready_o  out  1  request accepted this cycle when valid_i=1
valid_o  out  1  registered outputs valid
alu_ctrl_o  out  CTRL_W  ALU operation
result_sel_o  out  2  0=ALU, 1=shifter, 2=mul/div
left_right_o  out  1  1=shift right
shift_var_o  out  1  1=shift amount from rs
muldiv_start_o  out  1  one-cycle start pulse to mul/div unit
muldiv_op_o  out  1  0=mult, 1=div
muldiv_abort_o  out  1  one-cycle abort pulse
busy_o  out  1  multi-cycle operation in progress
illegal_o  out  1  unsupported encoding (qualified by valid_o)

Behaviour:
- Reset (rst_i low, async): all outputs 0, ready_o=0, state IDLE, counter 0.
- ready_o = (state==IDLE) && !(valid_o && stall_i). Accept = valid_i && ready_o at a rising edge.
- Decode for aluop 000 (R-type) by funct:
  - 100001 add -> 0010; 100011 sub -> 0110; 100100 and -> 0000; 100101 or -> 0001; 101010 slt -> 0111 (all sel 0).
  - 000000 sll -> sel1, lr0, var0; 000100 sllv -> sel1, lr0, var1.
  - 000011 sra -> sel1, lr1, var0; 000111 srav -> sel1, lr1, var1.
  - 011000 mult -> sel2, op0; 011010 div -> sel2, op1.
- Decode for other aluop values:
  - 001 addi -> 0010; 010 sltiu -> 0111; 011 beq -> 0110; 100 bne -> 0110; 110 ori -> 0001.
  - 101 lui -> sel1, lr0, var0.
- Unlisted funct or aluop 111: alu_ctrl 0000, sel 0, lr 0, var 0, illegal_o=1. Treated as single-cycle.
- Single-cycle op accepted at edge k: outputs and valid_o=1 registered at edge k.
- mult/div accepted at edge k:
  - State BUSY, counter=N-1 (N=MUL_CYCLES or DIV_CYCLES), muldiv_start_o=1 for cycle k only.
  - busy_o=1 and valid_o=0 during BUSY; decoded fields are registered at k and held.
  - Counter decrements each edge in BUSY. At the edge where counter==0: valid_o<=1, busy_o<=0, state IDLE, i.e. valid_o rises at edge k+N.
- Hold: valid_o && stall_i -> all outputs hold, no accept.
- Retire: valid_o && !stall_i with no accept -> valid_o<=0.
- Back-to-back single-cycle ops sustain 1/cycle.
- valid_i is ignored while ready_o=0; the requester must hold the request.
- flush_i (priority over accept and stall):
  - Next edge: valid_o=0, state IDLE, counter 0, busy_o=0.
  - If in BUSY: muldiv_abort_o=1 for one cycle.
  - No new request is accepted on the flush edge.
- Counter never wraps; a new mult/div cannot start while BUSY.
- Reset mid-BUSY: immediate return to reset values. No abort pulse.

Test Plan:
- Reset released, valid_i=1, aluop=000, funct=100011 -> one edge later valid_o=1, alu_ctrl_o=0110, sel=0, illegal_o=0.
- Stream add, sra, lui, ori on consecutive cycles, stall_i=0:
  - valid_o high 4 consecutive cycles.
  - Outputs per cycle: {0010,sel0}, {sel1,lr1,var0}, {sel1,lr0}, {0001}.
- mult with MUL_CYCLES=4 accepted at edge 0:
  - muldiv_start_o one cycle; busy_o 4 cycles; ready_o=0 throughout.
  - valid_o rises at edge 4 with sel=2, op=0.
- div accepted, flush_i pulsed at 5th BUSY cycle:
  - muldiv_abort_o one cycle; busy_o=0 and valid_o=0 after the flush edge.
  - ready_o=1 the following cycle.
- valid_o=1 with stall_i=1 for 3 cycles while valid_i=1 (and) -> outputs frozen, ready_o=0; and accepted on the first edge after stall_i drops.
- aluop=000 funct=111111, then aluop=111 -> illegal_o=1, alu_ctrl_o=0000 for each; rst_i pulsed low mid-BUSY -> all outputs 0 asynchronously.
